// File: rtl/hamming_nibble_assembler.sv
// Pairs decoded Hamming (8,4) nibbles into bytes with merged error flags, timeout and overrun detection.
// Optional saturating corrected/bad byte counters are enabled by defining HAM_ASM_STATS_EN.
module hamming_nibble_assembler #(
    parameter int HI_FIRST       = 1,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int DROP_BAD       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nib_valid,
    input  logic [3:0]  nib_data,
    input  logic        nib_single,
    input  logic        nib_double,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_corr,
    output logic        out_bad,
    output logic        timeout_err,
    output logic        overrun_err,
`ifdef HAM_ASM_STATS_EN
    output logic        bad_drop,
    output logic [15:0] corr_count,
    output logic [15:0] bad_count
`else
    output logic        bad_drop
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HALF = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_timer;
    logic [3:0]  r_half_data;
    logic        r_half_single;
    logic        r_half_double;

    logic [7:0]  r_out_data;
    logic        r_out_corr;
    logic        r_out_bad;
    logic        r_timeout_err;
    logic        r_overrun_err;
    logic        r_bad_drop;

    logic        w_capture;
    logic        w_form;
    logic        w_drop;
    logic        w_keep;
    logic        w_timeout;
    logic        w_overrun;
    logic        w_accept;
    logic [7:0]  w_byte;
    logic        w_corr;
    logic        w_bad;

    always_comb begin
        w_byte    = (HI_FIRST != 0) ? {r_half_data, nib_data} : {nib_data, r_half_data};
        w_corr    = r_half_single | nib_single;
        w_bad     = r_half_double | nib_double;
        w_accept  = (r_state == S_FULL) && out_ready;
        w_form    = (r_state == S_HALF) && nib_valid;
        w_drop    = w_form && (DROP_BAD != 0) && w_bad;
        w_keep    = w_form && !w_drop;
        // A second nibble arriving on the last timer cycle completes the byte instead of timing out.
        w_timeout = (r_state == S_HALF) && !nib_valid && (r_timer == TIMER_LAST);
        w_overrun = (r_state == S_FULL) && nib_valid && !out_ready;
        w_capture = nib_valid && ((r_state == S_IDLE) || w_accept);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (nib_valid) w_state_next = S_HALF;
            end
            S_HALF: begin
                if (w_keep)                  w_state_next = S_FULL;
                else if (w_drop || w_timeout) w_state_next = S_IDLE;
            end
            S_FULL: begin
                if (out_ready) w_state_next = nib_valid ? S_HALF : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer       <= '0;
            r_half_data   <= '0;
            r_half_single <= 1'b0;
            r_half_double <= 1'b0;
        end else begin
            if (w_capture) begin
                r_half_data   <= nib_data;
                r_half_single <= nib_single;
                r_half_double <= nib_double;
            end
            if (r_state == S_HALF && w_state_next == S_HALF) r_timer <= r_timer + 16'd1;
            else                                             r_timer <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data    <= '0;
            r_out_corr    <= 1'b0;
            r_out_bad     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
            r_bad_drop    <= 1'b0;
        end else begin
            if (w_keep) begin
                r_out_data <= w_byte;
                r_out_corr <= w_corr;
                r_out_bad  <= w_bad;
            end
            r_timeout_err <= w_timeout;
            r_overrun_err <= w_overrun;
            r_bad_drop    <= w_drop;
        end
    end

`ifdef HAM_ASM_STATS_EN
    logic [15:0] r_corr_count;
    logic [15:0] r_bad_count;
    logic        w_count_corr;
    logic        w_count_bad;

    // A byte counts once: at handshake if kept, at formation if dropped.
    always_comb begin
        w_count_corr = (w_accept && r_out_corr) || (w_drop && w_corr);
        w_count_bad  = (w_accept && r_out_bad)  || (w_drop && w_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_corr_count <= '0;
            r_bad_count  <= '0;
        end else begin
            if (w_count_corr && r_corr_count != '1) r_corr_count <= r_corr_count + 16'd1;
            if (w_count_bad  && r_bad_count  != '1) r_bad_count  <= r_bad_count + 16'd1;
        end
    end

    assign corr_count = r_corr_count;
    assign bad_count  = r_bad_count;
`endif

    assign out_valid   = (r_state == S_FULL);
    assign out_data    = r_out_data;
    assign out_corr    = r_out_corr;
    assign out_bad     = r_out_bad;
    assign timeout_err = r_timeout_err;
    assign overrun_err = r_overrun_err;
    assign bad_drop    = r_bad_drop;

endmodule

// File: tb/tb_hamming_nibble_assembler.sv
// Directed bench for hamming_nibble_assembler: three instances (keep-bad, drop-bad, low-nibble-first).
module tb_hamming_nibble_assembler;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       nib_single;
    logic       nib_double;
    logic       out_ready;

    logic       v0, c0, b0, t0, o0, d0;
    logic [7:0] q0;
    logic       v1, c1, b1, t1, o1, d1;
    logic [7:0] q1;
    logic       v2, c2, b2, t2, o2, d2;
    logic [7:0] q2;
`ifdef HAM_ASM_STATS_EN
    logic [15:0] cc0, bc0, cc1, bc1, cc2, bc2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hamming_nibble_assembler #(.HI_FIRST(1), .TIMEOUT_CYCLES(TMO), .DROP_BAD(0)) u_keep (
        .clk(clk), .rst(rst), .nib_valid(nib_valid), .nib_data(nib_data),
        .nib_single(nib_single), .nib_double(nib_double), .out_valid(v0), .out_ready(out_ready),
        .out_data(q0), .out_corr(c0), .out_bad(b0), .timeout_err(t0), .overrun_err(o0),
`ifdef HAM_ASM_STATS_EN
        .bad_drop(d0), .corr_count(cc0), .bad_count(bc0)
`else
        .bad_drop(d0)
`endif
    );

    hamming_nibble_assembler #(.HI_FIRST(1), .TIMEOUT_CYCLES(TMO), .DROP_BAD(1)) u_drop (
        .clk(clk), .rst(rst), .nib_valid(nib_valid), .nib_data(nib_data),
        .nib_single(nib_single), .nib_double(nib_double), .out_valid(v1), .out_ready(out_ready),
        .out_data(q1), .out_corr(c1), .out_bad(b1), .timeout_err(t1), .overrun_err(o1),
`ifdef HAM_ASM_STATS_EN
        .bad_drop(d1), .corr_count(cc1), .bad_count(bc1)
`else
        .bad_drop(d1)
`endif
    );

    hamming_nibble_assembler #(.HI_FIRST(0), .TIMEOUT_CYCLES(TMO), .DROP_BAD(0)) u_lofirst (
        .clk(clk), .rst(rst), .nib_valid(nib_valid), .nib_data(nib_data),
        .nib_single(nib_single), .nib_double(nib_double), .out_valid(v2), .out_ready(out_ready),
        .out_data(q2), .out_corr(c2), .out_bad(b2), .timeout_err(t2), .overrun_err(o2),
`ifdef HAM_ASM_STATS_EN
        .bad_drop(d2), .corr_count(cc2), .bad_count(bc2)
`else
        .bad_drop(d2)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic s, input logic dbl);
        nib_valid  = 1'b1;
        nib_data   = d;
        nib_single = s;
        nib_double = dbl;
        tick();
        nib_valid  = 1'b0;
        nib_data   = 4'h0;
        nib_single = 1'b0;
        nib_double = 1'b0;
    endtask

    initial begin
        rst = 1'b1; nib_valid = 1'b0; nib_data = 4'h0;
        nib_single = 1'b0; nib_double = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", {15'd0, v0}, 16'd0);
        check("rst_data",  {8'd0, q0}, 16'd0);
        check("rst_pulses", {13'd0, t0, o0, d0}, 16'd0);

        // basic pair A,5
        send(4'hA, 1'b0, 1'b0);
        check("half_no_valid", {15'd0, v0}, 16'd0);
        send(4'h5, 1'b0, 1'b0);
        check("a5_valid", {15'd0, v0}, 16'd1);
        check("a5_data",  {8'd0, q0}, 16'h00A5);
        check("a5_flags", {14'd0, c0, b0}, 16'd0);
        check("lofirst_5a", {8'd0, q2}, 16'h005A);
        tick();
        check("a5_one_cycle", {15'd0, v0}, 16'd0);

        // corrected first nibble
        send(4'h3, 1'b1, 1'b0);
        send(4'hC, 1'b0, 1'b0);
        check("3c_data", {8'd0, q0}, 16'h003C);
        check("3c_corr", {14'd0, c0, b0}, 16'd2);
        tick();
`ifdef HAM_ASM_STATS_EN
        check("3c_corr_count", cc0, 16'd1);
`endif

        // timeout exactly at TMO cycles
        send(4'h1, 1'b0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) tick();
        check("tmo_not_yet", {15'd0, t0}, 16'd0);
        tick();
        check("tmo_pulse", {15'd0, t0}, 16'd1);
        check("tmo_no_valid", {15'd0, v0}, 16'd0);
        tick();
        check("tmo_one_cycle", {15'd0, t0}, 16'd0);
        send(4'h7, 1'b0, 1'b0);
        send(4'h8, 1'b0, 1'b0);
        check("78_data", {8'd0, q0}, 16'h0078);
        check("78_valid", {15'd0, v0}, 16'd1);
        tick();

        // second nibble on the last timer cycle wins
        send(4'h4, 1'b0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) tick();
        send(4'h6, 1'b0, 1'b0);
        check("edge_data", {8'd0, q0}, 16'h0046);
        check("edge_no_tmo", {15'd0, t0}, 16'd0);
        tick();

        // overrun while output held
        out_ready = 1'b0;
        send(4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 1'b0);
        tick();
        check("hold_valid", {15'd0, v0}, 16'd1);
        check("hold_data", {8'd0, q0}, 16'h0012);
        send(4'hF, 1'b0, 1'b0);
        check("ovr_pulse", {15'd0, o0}, 16'd1);
        check("ovr_data", {8'd0, q0}, 16'h0012);
        check("ovr_valid", {15'd0, v0}, 16'd1);
        tick();
        check("ovr_one_cycle", {15'd0, o0}, 16'd0);
        // handshake with simultaneous first nibble
        out_ready = 1'b1;
        send(4'h9, 1'b0, 1'b0);
        check("hs_new_half", {15'd0, v0}, 16'd0);
        send(4'hD, 1'b0, 1'b0);
        check("9d_data", {8'd0, q0}, 16'h009D);
        tick();

        // double error on second nibble
        send(4'h5, 1'b0, 1'b0);
        send(4'h6, 1'b0, 1'b1);
        check("keep_bad_valid", {15'd0, v0}, 16'd1);
        check("keep_bad_flag", {14'd0, c0, b0}, 16'd1);
        check("keep_bad_data", {8'd0, q0}, 16'h0056);
        check("drop_pulse", {15'd0, d1}, 16'd1);
        check("drop_no_valid", {15'd0, v1}, 16'd0);
        check("keep_no_drop", {15'd0, d0}, 16'd0);
        tick();
        check("drop_one_cycle", {15'd0, d1}, 16'd0);
`ifdef HAM_ASM_STATS_EN
        check("keep_bad_count", bc0, 16'd1);
        check("drop_bad_count", bc1, 16'd1);
`endif
        // double error on first nibble also dropped
        send(4'hA, 1'b0, 1'b1);
        send(4'hB, 1'b1, 1'b0);
        check("drop1_pulse", {15'd0, d1}, 16'd1);
        check("drop1_no_valid", {15'd0, v1}, 16'd0);
        check("keep1_flags", {14'd0, c0, b0}, 16'd3);
        tick();

        // reset mid-byte
        send(4'h2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", {15'd0, v0}, 16'd0);
`ifdef HAM_ASM_STATS_EN
        check("rst_counts", {cc0[7:0], bc0[7:0]}, 16'd0);
`endif
        send(4'h3, 1'b0, 1'b0);
        check("rst_mid_half", {15'd0, v0}, 16'd0);
        send(4'h4, 1'b0, 1'b0);
        check("34_data", {8'd0, q0}, 16'h0034);
        check("34_valid", {15'd0, v0}, 16'd1);

        // reset while FULL
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_full_valid", {15'd0, v0}, 16'd0);
        check("rst_full_data", {8'd0, q0}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
